// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcodes, ALU selects and sequencer state encoding
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_CODE_W = 3;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_NEG  = 3'd2;
   localparam logic [2:0] OP_NOT  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_CMP  = 3'd5;
   localparam logic [2:0] OP_ABS  = 3'd6;
   localparam logic [2:0] OP_RSVD = 3'd7;

   localparam logic [1:0] SEL_ADD = 2'd0;
   localparam logic [1:0] SEL_NOT = 2'd1;
   localparam logic [1:0] SEL_NEG = 2'd2;
   localparam logic [1:0] SEL_AND = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS1 = 2'd1,
      ST_PASS2 = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic is_two_pass(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_CMP) || (op == OP_ABS);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_flag_gen.sv
// ============================================================================
// Module   : alu_flag_gen
// Purpose  : Combinational Z/N/C/V flags for a finished ALU operation
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int CODE_W = DEF_CODE_W
) (
   input  logic [CODE_W-1:0] op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [WIDTH-1:0]  x,
   input  logic              cout,
   output logic              z,
   output logic              n,
   output logic              c,
   output logic              v
);

   localparam int MSB = WIDTH - 1;

   always_comb begin
      z = (x == '0);
      n = x[MSB];
      c = 1'b0;
      v = 1'b0;
      case (op)
         OP_ADD: begin
            c = cout;
            v = (a[MSB] == b[MSB]) && (x[MSB] != a[MSB]);
         end
         OP_SUB, OP_CMP: begin
            // a + (-0) never carries, yet nothing is borrowed
            c = cout || (b == '0);
            v = (a[MSB] != b[MSB]) && (x[MSB] != a[MSB]);
         end
         OP_ABS: begin
            // only the most negative input yields a negative magnitude
            v = x[MSB];
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Request/response front end sequencing one- and two-pass ALU ops
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int CODE_W = DEF_CODE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CODE_W-1:0] req_op,
   input  logic [WIDTH-1:0]  req_a,
   input  logic [WIDTH-1:0]  req_b,
   output logic [1:0]        alu_sel,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   input  logic [WIDTH-1:0]  alu_x,
   input  logic              alu_cout,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_x,
   output logic              rsp_z,
   output logic              rsp_n,
   output logic              rsp_c,
   output logic              rsp_v,
   output logic              rsp_err
);

   localparam int MSB = WIDTH - 1;

   state_t            r_state, w_state_nxt;
   logic [CODE_W-1:0] r_op, w_op_nxt;
   logic [WIDTH-1:0]  r_a, w_a_nxt;
   logic [WIDTH-1:0]  r_b, w_b_nxt;
   logic [WIDTH-1:0]  r_tmp, w_tmp_nxt;
   logic [1:0]        r_alu_sel, w_alu_sel_nxt;
   logic [WIDTH-1:0]  r_alu_a, w_alu_a_nxt;
   logic [WIDTH-1:0]  r_alu_b, w_alu_b_nxt;
   logic [WIDTH-1:0]  r_rsp_x, w_rsp_x_nxt;
   logic              r_z, w_z_nxt;
   logic              r_n, w_n_nxt;
   logic              r_c, w_c_nxt;
   logic              r_v, w_v_nxt;
   logic              r_err, w_err_nxt;

   logic [WIDTH-1:0]  w_abs;
   logic [WIDTH-1:0]  w_flag_x;
   logic              w_z, w_n, w_c, w_v;

   assign w_abs    = r_a[MSB] ? r_tmp : r_a;
   assign w_flag_x = ((r_state == ST_PASS2) && (r_op == OP_ABS)) ? w_abs : alu_x;

   alu_flag_gen #(
      .WIDTH  (WIDTH),
      .CODE_W (CODE_W)
   ) u_flag_gen (
      .op   (r_op),
      .a    (r_a),
      .b    (r_b),
      .x    (w_flag_x),
      .cout (alu_cout),
      .z    (w_z),
      .n    (w_n),
      .c    (w_c),
      .v    (w_v)
   );

   assign req_ready = (r_state == ST_IDLE) && !reset;
   assign rsp_valid = (r_state == ST_DONE);
   assign alu_sel   = r_alu_sel;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign rsp_x     = r_rsp_x;
   assign rsp_z     = r_z;
   assign rsp_n     = r_n;
   assign rsp_c     = r_c;
   assign rsp_v     = r_v;
   assign rsp_err   = r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_op      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_tmp     <= '0;
         r_alu_sel <= SEL_ADD;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_rsp_x   <= '0;
         r_z       <= 1'b0;
         r_n       <= 1'b0;
         r_c       <= 1'b0;
         r_v       <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_op      <= w_op_nxt;
         r_a       <= w_a_nxt;
         r_b       <= w_b_nxt;
         r_tmp     <= w_tmp_nxt;
         r_alu_sel <= w_alu_sel_nxt;
         r_alu_a   <= w_alu_a_nxt;
         r_alu_b   <= w_alu_b_nxt;
         r_rsp_x   <= w_rsp_x_nxt;
         r_z       <= w_z_nxt;
         r_n       <= w_n_nxt;
         r_c       <= w_c_nxt;
         r_v       <= w_v_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // ALU drive registers are loaded for the state being entered, else zero
   always_comb begin
      w_state_nxt   = r_state;
      w_op_nxt      = r_op;
      w_a_nxt       = r_a;
      w_b_nxt       = r_b;
      w_tmp_nxt     = r_tmp;
      w_alu_sel_nxt = SEL_ADD;
      w_alu_a_nxt   = '0;
      w_alu_b_nxt   = '0;
      w_rsp_x_nxt   = r_rsp_x;
      w_z_nxt       = r_z;
      w_n_nxt       = r_n;
      w_c_nxt       = r_c;
      w_v_nxt       = r_v;
      w_err_nxt     = r_err;

      case (r_state)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               w_op_nxt    = req_op;
               w_a_nxt     = req_a;
               w_b_nxt     = req_b;
               w_state_nxt = ST_PASS1;
               case (req_op)
                  OP_ADD: begin
                     w_alu_sel_nxt = SEL_ADD;
                     w_alu_a_nxt   = req_a;
                     w_alu_b_nxt   = req_b;
                  end
                  OP_AND: begin
                     w_alu_sel_nxt = SEL_AND;
                     w_alu_a_nxt   = req_a;
                     w_alu_b_nxt   = req_b;
                  end
                  OP_NOT: begin
                     w_alu_sel_nxt = SEL_NOT;
                     w_alu_a_nxt   = req_a;
                  end
                  OP_NEG, OP_ABS: begin
                     w_alu_sel_nxt = SEL_NEG;
                     w_alu_a_nxt   = req_a;
                  end
                  OP_SUB, OP_CMP: begin
                     w_alu_sel_nxt = SEL_NEG;
                     w_alu_a_nxt   = req_b;
                  end
                  default: begin
                     w_state_nxt = ST_DONE;
                     w_rsp_x_nxt = '0;
                     w_z_nxt     = 1'b0;
                     w_n_nxt     = 1'b0;
                     w_c_nxt     = 1'b0;
                     w_v_nxt     = 1'b0;
                     w_err_nxt   = 1'b1;
                  end
               endcase
            end
         end

         ST_PASS1: begin
            if (is_two_pass(r_op)) begin
               w_tmp_nxt     = alu_x;
               w_state_nxt   = ST_PASS2;
               w_alu_sel_nxt = SEL_ADD;
               if (r_op == OP_ABS) begin
                  // pass-through step: magnitude + 0
                  w_alu_a_nxt = r_a[MSB] ? alu_x : r_a;
               end else begin
                  w_alu_a_nxt = r_a;
                  w_alu_b_nxt = alu_x;
               end
            end else begin
               w_rsp_x_nxt = alu_x;
               w_z_nxt     = w_z;
               w_n_nxt     = w_n;
               w_c_nxt     = w_c;
               w_v_nxt     = w_v;
               w_err_nxt   = 1'b0;
               w_state_nxt = ST_DONE;
            end
         end

         ST_PASS2: begin
            if (r_op == OP_CMP) begin
               w_rsp_x_nxt = r_a;
            end else if (r_op == OP_ABS) begin
               w_rsp_x_nxt = w_abs;
            end else begin
               w_rsp_x_nxt = alu_x;
            end
            w_z_nxt     = w_z;
            w_n_nxt     = w_n;
            w_c_nxt     = w_c;
            w_v_nxt     = w_v;
            w_err_nxt   = 1'b0;
            w_state_nxt = ST_DONE;
         end

         ST_DONE: begin
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Randomized bench with an arithmetic reference model and ALU model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic [1:0] alu_sel;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_x;
   logic       alu_cout;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_x;
   logic       rsp_z, rsp_n, rsp_c, rsp_v, rsp_err;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(8), .CODE_W(3)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_sel   (alu_sel),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_x     (alu_x),
      .alu_cout  (alu_cout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_x     (rsp_x),
      .rsp_z     (rsp_z),
      .rsp_n     (rsp_n),
      .rsp_c     (rsp_c),
      .rsp_v     (rsp_v),
      .rsp_err   (rsp_err)
   );

   // Combinational ALU datapath the sequencer drives
   logic [8:0] w_sum;
   always_comb begin
      w_sum    = {1'b0, alu_a} + {1'b0, alu_b};
      alu_x    = 8'h00;
      alu_cout = 1'b0;
      case (alu_sel)
         2'd0: {alu_cout, alu_x} = w_sum;
         2'd1: alu_x = ~alu_a;
         2'd2: alu_x = 8'(~alu_a + 8'd1);
         default: alu_x = alu_a & alu_b;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected {err, v, c, n, z, x} from plain integer arithmetic
   function automatic logic [12:0] model(input int op, input int a, input int b);
      int x, sa, sb, r;
      logic z, n, c, v, e;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      c = 1'b0; v = 1'b0; e = 1'b0; x = 0;
      case (op)
         0: begin x = (a + b) & 255; c = ((a + b) > 255); r = sa + sb; v = (r > 127) || (r < -128); end
         1, 5: begin x = (a - b) & 255; c = (a >= b); r = sa - sb; v = (r > 127) || (r < -128); end
         2: x = (256 - a) & 255;
         3: x = 255 - a;
         4: x = a & b;
         6: begin x = ((sa < 0) ? -sa : sa) & 255; v = (a == 128); end
         default: e = 1'b1;
      endcase
      z = (x == 0);
      n = (x > 127);
      if (op == 5) x = a;
      if (op == 7) begin z = 1'b0; n = 1'b0; end
      return {e, v, c, n, z, 8'(x)};
   endfunction

   task automatic wait_idle();
      for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
      check("req_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
      logic [12:0] exp;
      int          lat, k, iop;
      logic [1:0]  exp_sel;
      logic [7:0]  exp_a;
      logic        seen;
      iop = int'(op);
      exp = model(iop, int'(a), int'(b));
      lat = (iop == 7) ? 1 : (iop == 1 || iop == 5 || iop == 6) ? 3 : 2;
      exp_sel = (iop == 0) ? 2'd0 : (iop == 3) ? 2'd1 : (iop == 4) ? 2'd3 : 2'd2;
      exp_a   = (iop == 1 || iop == 5) ? b : a;
      wait_idle();
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      @(posedge clk);
      #1 req_valid = 1'b0;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 10) begin
         @(negedge clk);
         k++;
         if (k == 1 && iop != 7) begin
            check("pass1_sel", 32'(alu_sel), 32'(exp_sel));
            check("pass1_a", 32'(alu_a), 32'(exp_a));
         end
         if (k == 2 && lat == 3) check("pass2_sel", 32'(alu_sel), 32'd0);
         if (rsp_valid) seen = 1'b1;
      end
      check("latency", 32'(k), 32'(lat));
      if (seen) begin
         check("rsp", 32'({rsp_err, rsp_v, rsp_c, rsp_n, rsp_z, rsp_x}), 32'(exp));
         check("done_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold", 32'({rsp_valid, req_ready, rsp_err, rsp_v, rsp_c, rsp_n, rsp_z, rsp_x}),
                  32'({2'b10, exp}));
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         check("to_idle", 32'({rsp_valid, req_ready}), 32'b01);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] edge_vals [5];
      logic [7:0] ra, rb;
      edge_vals[0] = 8'h00; edge_vals[1] = 8'h7F; edge_vals[2] = 8'h80;
      edge_vals[3] = 8'hFF; edge_vals[4] = 8'h01;

      reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 8'h00; req_b = 8'h00; rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_outs", 32'({rsp_valid, rsp_err, rsp_v, rsp_c, rsp_n, rsp_z, rsp_x}), 32'd0);
      check("rst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(req_ready), 32'd1);

      run_op(3'd0, 8'h7F, 8'h01, 0);
      run_op(3'd1, 8'h05, 8'h05, 0);
      run_op(3'd1, 8'h00, 8'h00, 0);
      run_op(3'd6, 8'h80, 8'h00, 0);
      run_op(3'd6, 8'hFB, 8'h00, 0);
      run_op(3'd6, 8'h05, 8'h00, 0);
      run_op(3'd5, 8'h03, 8'h07, 5);
      run_op(3'd7, 8'h12, 8'h34, 1);
      run_op(3'd3, 8'h0F, 8'h00, 0);
      run_op(3'd2, 8'h80, 8'h00, 0);
      run_op(3'd4, 8'hF0, 8'h3C, 0);

      // reset while a SUB sits in its second pass
      wait_idle();
      req_valid = 1'b1; req_op = 3'd1; req_a = 8'h20; req_b = 8'h10;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_pass2_sel", 32'(alu_sel), 32'd0);
      check("pre_rst_pass2_a", 32'(alu_a), 32'h20);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_outs", 32'({rsp_valid, req_ready, rsp_err, rsp_v, rsp_c, rsp_n, rsp_z, rsp_x}), 32'd0);
      check("midrst_alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_ready", 32'({rsp_valid, req_ready}), 32'b01);

      for (int t = 0; t < 80; t++) begin
         ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 8'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 8'($urandom);
         run_op(3'($urandom_range(0, 7)), ra, rb, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
